// File: rtl/rv_core_pkg.sv
// Shared core types and constants used by the MEM-stage load/store unit.
package rv_core_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned OP_W   = 4;

    localparam logic [OP_W-1:0] OP_LW = 4'b1010;
    localparam logic [OP_W-1:0] OP_SW = 4'b1011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } lsu_state_e;

    // Data-memory request payload held stable while the request is pending
    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } dmem_req_t;

    // MEM/WB write-back payload
    typedef struct packed {
        logic [REG_AW-1:0] rd_addr;
        logic              rd_we;
        logic [XLEN-1:0]   rd_data;
    } wb_t;

endpackage

// File: rtl/lsu_timeout_ctr.sv
// Load-response timeout counter: clears on request acceptance, counts WAIT cycles.
module lsu_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [CNT_W-1:0] count;

    // Counter register; clear has priority over increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues LW/SW to data memory, stalls upstream
// while an access is outstanding and produces registered MEM/WB fields.
module mem_stage_lsu
    import rv_core_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] mem_rd_addr,
    input  logic              mem_rd_we,
    input  logic [XLEN-1:0]   mem_rd_data,
    input  logic [XLEN-1:0]   mem_mem_addr,
    input  logic [OP_W-1:0]   mem_alu_op,
    input  logic [XLEN-1:0]   mem_op_2,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic              dmem_req_we,
    output logic [XLEN-1:0]   dmem_req_addr,
    output logic [XLEN-1:0]   dmem_req_wdata,
    input  logic              dmem_resp_valid,
    input  logic [XLEN-1:0]   dmem_resp_rdata,
    output logic              stall,
    output logic [REG_AW-1:0] wb_rd_addr,
    output logic              wb_rd_we,
    output logic [XLEN-1:0]   wb_rd_data,
    output logic              misalign_err,
    output logic              bus_err
);

    lsu_state_e        state;
    dmem_req_t         req;
    wb_t               wb;
    logic [REG_AW-1:0] rd_addr_q;
    logic              rd_we_q;

    logic is_ld;
    logic is_st;
    logic is_mem;
    logic aligned;
    logic ctr_clr;
    logic ctr_en;
    logic expired;

    assign is_ld   = (mem_alu_op == OP_LW);
    assign is_st   = (mem_alu_op == OP_SW);
    assign is_mem  = is_ld | is_st;
    assign aligned = (mem_mem_addr[1:0] == 2'b00);

    // Counter restarts when a load is accepted and runs while the response is outstanding
    assign ctr_clr = (state == S_REQ) && dmem_req_ready && !req.we;
    assign ctr_en  = (state == S_WAIT) && !dmem_resp_valid && !expired;

    lsu_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timeout_ctr (
        .clk     (clk),
        .reset   (reset),
        .clr     (ctr_clr),
        .en      (ctr_en),
        .expired (expired)
    );

    // Upstream hold: low only when the MEM-stage instruction completes this cycle
    assign stall = ((state == S_IDLE) && is_mem && aligned)
                || ((state == S_REQ)  && !(dmem_req_ready && req.we))
                || ((state == S_WAIT) && !dmem_resp_valid && !expired);

    // Access FSM with request, write-back and error-pulse registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            req            <= '0;
            wb             <= '0;
            rd_addr_q      <= '0;
            rd_we_q        <= 1'b0;
            dmem_req_valid <= 1'b0;
            misalign_err   <= 1'b0;
            bus_err        <= 1'b0;
        end else begin
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!is_mem) begin
                        wb.rd_addr <= mem_rd_addr;
                        wb.rd_we   <= mem_rd_we && (mem_rd_addr != '0);
                        wb.rd_data <= mem_rd_data;
                    end else if (!aligned) begin
                        wb.rd_we     <= 1'b0;
                        misalign_err <= 1'b1;
                    end else begin
                        wb.rd_we       <= 1'b0;
                        req.we         <= is_st;
                        req.addr       <= mem_mem_addr;
                        req.wdata      <= mem_op_2;
                        rd_addr_q      <= mem_rd_addr;
                        rd_we_q        <= mem_rd_we;
                        dmem_req_valid <= 1'b1;
                        state          <= S_REQ;
                    end
                end
                S_REQ: begin
                    wb.rd_we <= 1'b0;
                    if (dmem_req_ready) begin
                        dmem_req_valid <= 1'b0;
                        state          <= req.we ? S_IDLE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (dmem_resp_valid) begin
                        wb.rd_addr <= rd_addr_q;
                        wb.rd_we   <= rd_we_q && (rd_addr_q != '0);
                        wb.rd_data <= dmem_resp_rdata;
                        state      <= S_IDLE;
                    end else if (expired) begin
                        wb.rd_we <= 1'b0;
                        bus_err  <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        wb.rd_we <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign dmem_req_we    = req.we;
    assign dmem_req_addr  = req.addr;
    assign dmem_req_wdata = req.wdata;
    assign wb_rd_addr     = wb.rd_addr;
    assign wb_rd_we       = wb.rd_we;
    assign wb_rd_data     = wb.rd_data;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu (timeout shortened to 4 cycles).
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  mem_rd_addr;
    logic        mem_rd_we;
    logic [31:0] mem_rd_data;
    logic [31:0] mem_mem_addr;
    logic [3:0]  mem_alu_op;
    logic [31:0] mem_op_2;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_req_we;
    logic [31:0] dmem_req_addr;
    logic [31:0] dmem_req_wdata;
    logic        dmem_resp_valid;
    logic [31:0] dmem_resp_rdata;
    logic        stall;
    logic [4:0]  wb_rd_addr;
    logic        wb_rd_we;
    logic [31:0] wb_rd_data;
    logic        misalign_err;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    localparam logic [3:0] LW  = 4'b1010;
    localparam logic [3:0] SW  = 4'b1011;
    localparam logic [3:0] ADD = 4'b0000;

    mem_stage_lsu #(
        .TIMEOUT_CYCLES (4),
        .CNT_W          (3)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .mem_rd_addr     (mem_rd_addr),
        .mem_rd_we       (mem_rd_we),
        .mem_rd_data     (mem_rd_data),
        .mem_mem_addr    (mem_mem_addr),
        .mem_alu_op      (mem_alu_op),
        .mem_op_2        (mem_op_2),
        .dmem_req_valid  (dmem_req_valid),
        .dmem_req_ready  (dmem_req_ready),
        .dmem_req_we     (dmem_req_we),
        .dmem_req_addr   (dmem_req_addr),
        .dmem_req_wdata  (dmem_req_wdata),
        .dmem_resp_valid (dmem_resp_valid),
        .dmem_resp_rdata (dmem_resp_rdata),
        .stall           (stall),
        .wb_rd_addr      (wb_rd_addr),
        .wb_rd_we        (wb_rd_we),
        .wb_rd_data      (wb_rd_data),
        .misalign_err    (misalign_err),
        .bus_err         (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [4:0] rd, input logic we,
                         input logic [31:0] data, input logic [31:0] addr, input logic [31:0] op2);
        mem_alu_op   = op;
        mem_rd_addr  = rd;
        mem_rd_we    = we;
        mem_rd_data  = data;
        mem_mem_addr = addr;
        mem_op_2     = op2;
    endtask

    // Advance one clock and land 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset           = 1'b1;
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b0;
        dmem_resp_rdata = 32'h0;
        drive(ADD, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);
        tick();
        tick();
        chk1("rst_valid", dmem_req_valid, 1'b0);
        chk1("rst_stall", stall, 1'b0);
        chk1("rst_wb_we", wb_rd_we, 1'b0);
        chk ("rst_wb_data", wb_rd_data, 32'h0);
        chk1("rst_bus_err", bus_err, 1'b0);
        reset = 1'b0;

        // ALU pass-through
        drive(ADD, 5'd5, 1'b1, 32'h1234, 32'h0, 32'h0);
        #2 chk1("add_stall", stall, 1'b0);
        tick();
        chk ("add_wb_addr", 32'(wb_rd_addr), 32'd5);
        chk1("add_wb_we", wb_rd_we, 1'b1);
        chk ("add_wb_data", wb_rd_data, 32'h1234);

        // Load: ready at once, response in first WAIT cycle
        drive(LW, 5'd3, 1'b1, 32'h0, 32'h100, 32'h0);
        dmem_req_ready = 1'b1;
        #2 chk1("ld_idle_stall", stall, 1'b1);
        chk1("ld_idle_valid", dmem_req_valid, 1'b0);
        tick();
        chk1("ld_req_valid", dmem_req_valid, 1'b1);
        chk ("ld_req_addr", dmem_req_addr, 32'h100);
        chk1("ld_req_we", dmem_req_we, 1'b0);
        chk1("ld_req_stall", stall, 1'b1);
        chk1("ld_bubble_we", wb_rd_we, 1'b0);
        tick();
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 32'hDEADBEEF;
        #2 chk1("ld_wait_valid", dmem_req_valid, 1'b0);
        chk1("ld_wait_stall", stall, 1'b0);
        tick();
        dmem_resp_valid = 1'b0;
        chk ("ld_wb_addr", 32'(wb_rd_addr), 32'd3);
        chk1("ld_wb_we", wb_rd_we, 1'b1);
        chk ("ld_wb_data", wb_rd_data, 32'hDEADBEEF);

        // Store with ready held low for three cycles
        drive(SW, 5'd7, 1'b0, 32'h0, 32'h40, 32'hCAFEF00D);
        #2 chk1("st_idle_stall", stall, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            dmem_req_ready = (i == 3);
            #2 chk1("st_req_valid", dmem_req_valid, 1'b1);
            chk ("st_req_addr", dmem_req_addr, 32'h40);
            chk ("st_req_wdata", dmem_req_wdata, 32'hCAFEF00D);
            chk1("st_req_we", dmem_req_we, 1'b1);
            chk1("st_req_stall", stall, (i != 3));
            tick();
        end
        dmem_req_ready = 1'b0;
        chk1("st_done_valid", dmem_req_valid, 1'b0);
        chk1("st_wb_we", wb_rd_we, 1'b0);

        // Misaligned load after a writing ALU op
        drive(ADD, 5'd9, 1'b1, 32'h55, 32'h0, 32'h0);
        tick();
        chk1("pre_mis_we", wb_rd_we, 1'b1);
        drive(LW, 5'd4, 1'b1, 32'h0, 32'h102, 32'h0);
        #2 chk1("mis_stall", stall, 1'b0);
        chk1("mis_valid", dmem_req_valid, 1'b0);
        tick();
        chk1("mis_err", misalign_err, 1'b1);
        chk1("mis_wb_we", wb_rd_we, 1'b0);
        chk1("mis_no_req", dmem_req_valid, 1'b0);
        drive(ADD, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);
        tick();
        chk1("mis_err_pulse", misalign_err, 1'b0);

        // Load timeout after four WAIT cycles, then a late response is ignored
        drive(LW, 5'd6, 1'b1, 32'h0, 32'h200, 32'h0);
        dmem_req_ready = 1'b1;
        tick();
        tick();
        dmem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #2 chk1("to_wait_stall", stall, (i < 3));
            chk1("to_wait_bus_err", bus_err, 1'b0);
            tick();
        end
        chk1("to_bus_err", bus_err, 1'b1);
        chk1("to_wb_we", wb_rd_we, 1'b0);
        drive(ADD, 5'd10, 1'b1, 32'hABC, 32'h0, 32'h0);
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 32'h11111111;
        #2 chk1("late_stall", stall, 1'b0);
        tick();
        dmem_resp_valid = 1'b0;
        chk1("to_bus_err_pulse", bus_err, 1'b0);
        chk ("late_wb_addr", 32'(wb_rd_addr), 32'd10);
        chk1("late_wb_we", wb_rd_we, 1'b1);
        chk ("late_wb_data", wb_rd_data, 32'hABC);

        // Reset asserted while waiting for a load response
        drive(LW, 5'd8, 1'b1, 32'h0, 32'h300, 32'h0);
        dmem_req_ready = 1'b1;
        tick();
        tick();
        dmem_req_ready = 1'b0;
        #2 chk1("rw_wait_stall", stall, 1'b1);
        reset = 1'b1;
        drive(ADD, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);
        #1 chk1("rw_valid", dmem_req_valid, 1'b0);
        chk ("rw_wb_addr", 32'(wb_rd_addr), 32'd0);
        chk ("rw_wb_data", wb_rd_data, 32'h0);
        chk1("rw_stall", stall, 1'b0);
        tick();
        reset = 1'b0;
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 32'h99999999;
        #2 chk1("rw_late_stall", stall, 1'b0);
        tick();
        dmem_resp_valid = 1'b0;
        chk1("rw_late_we", wb_rd_we, 1'b0);
        chk ("rw_late_data", wb_rd_data, 32'h0);

        // Load to x0 never writes back
        drive(LW, 5'd0, 1'b1, 32'h0, 32'h0, 32'h0);
        dmem_req_ready = 1'b1;
        tick();
        tick();
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 32'h77;
        #2 chk1("x0_stall", stall, 1'b0);
        tick();
        dmem_resp_valid = 1'b0;
        drive(ADD, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);
        chk1("x0_wb_we", wb_rd_we, 1'b0);
        chk ("x0_wb_data", wb_rd_data, 32'h77);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
